gray_ptr_rd_ctrl: RTL and testbench

- Read-side pointer controller for a dual-clock FIFO, running in the read clock domain.
- The write domain sends its pointer in Gray code. This block synchronizes that pointer and converts it back to binary (the receiving end of the bin2gray/gray2bin path).
- It owns the local read pointer and sends that pointer back in Gray code. It produces empty, level, almost-empty and overflow-error status for the consumer and the FIFO RAM.

---
 rtl/cdc_pkg.sv | 27 ++
 rtl/cdc_sync_bus.sv | 30 +++
 rtl/gray_ptr_rd_ctrl.sv | 75 +++++++
 tb/tb_gray_ptr_rd_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared helpers for the dual-clock FIFO pointer path: pointer sizing and
// Gray/binary conversion used on both sides of the clock crossing.
package cdc_pkg;

  // One extra pointer bit beyond the address distinguishes full from empty.
  localparam int unsigned PTR_EXTRA  = 1;
  localparam int unsigned GRAY_MAX_W = 32;

  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + PTR_EXTRA;
  endfunction

  // Both functions work on zero-extended values; callers truncate the result.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Plain WIDTH x STAGES flop chain for a Gray-coded bus crossing clock domains.
// No logic between stages; STAGES must be 2 or more.
module cdc_sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_rd_ctrl.sv
// Read-side pointer controller of a dual-clock FIFO: synchronizes the writer's
// Gray pointer, owns the read pointer and produces empty/level/status flags.
module gray_ptr_rd_ctrl
  import cdc_pkg::*;
#(
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW:0]   wr_gray_i,
  input  logic          rd_en_i,
  output logic          rd_ok_o,
  output logic [AW-1:0] rd_addr_o,
  output logic [AW:0]   rd_gray_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          almost_empty_o,
  output logic          ovf_err_o
);

  localparam int PW = ptr_width(AW);
  localparam logic [PW-1:0] AE_LVL   = PW'(AE_THRESH);
  localparam logic [PW-1:0] FULL_LVL = PW'(1) << AW;

  logic [PW-1:0] wr_gray_s;
  logic [PW-1:0] wr_bin_s;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] level_next;

  cdc_sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (wr_gray_i),
    .q_o   (wr_gray_s)
  );

  assign wr_bin_s = PW'(gray2bin(GRAY_MAX_W'(wr_gray_s)));

  // Handshake: the consumer holds rd_en_i while it wants data; a pop happens
  // exactly on the cycles where rd_ok_o is high, never while empty_o is set.
  assign rd_ok_o      = rd_en_i & ~empty_o;
  assign rd_bin_next  = rd_bin + PW'(rd_ok_o);
  assign rd_gray_next = PW'(bin2gray(GRAY_MAX_W'(rd_bin_next)));
  assign level_next   = wr_bin_s - rd_bin_next;
  assign rd_addr_o    = rd_bin[AW-1:0];

  // Status is computed from next-state values so a pop is visible one edge later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_bin         <= '0;
      rd_gray_o      <= '0;
      empty_o        <= 1'b1;
      level_o        <= '0;
      almost_empty_o <= 1'b1;
      ovf_err_o      <= 1'b0;
    end else begin
      rd_bin         <= rd_bin_next;
      rd_gray_o      <= rd_gray_next;
      empty_o        <= (wr_gray_s == rd_gray_next);
      level_o        <= level_next;
      almost_empty_o <= (level_next <= AE_LVL);
      if (level_next > FULL_LVL) begin
        ovf_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gray_ptr_rd_ctrl.sv
// Directed bench for gray_ptr_rd_ctrl: driver pushes hand-computed expected
// output snapshots, a negedge monitor pops and compares them.
module tb_gray_ptr_rd_ctrl;

  localparam int W = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] wr_gray;
  logic       rd_en;
  logic       rd_ok;
  logic [3:0] rd_addr;
  logic [4:0] rd_gray;
  logic       empty;
  logic [4:0] level;
  logic       almost_empty;
  logic       ovf_err;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  gray_ptr_rd_ctrl #(
    .AW          (4),
    .SYNC_STAGES (2),
    .AE_THRESH   (1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_gray_i      (wr_gray),
    .rd_en_i        (rd_en),
    .rd_ok_o        (rd_ok),
    .rd_addr_o      (rd_addr),
    .rd_gray_o      (rd_gray),
    .empty_o        (empty),
    .level_o        (level),
    .almost_empty_o (almost_empty),
    .ovf_err_o      (ovf_err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic step(input logic [4:0] wg, input logic re);
    @(posedge clk);
    #1;
    wr_gray = wg;
    rd_en   = re;
  endtask

  task automatic expect_out(input string nm, input logic ok, input logic e,
                            input logic ae, input logic ov, input logic [4:0] lvl,
                            input logic [4:0] g, input logic [3:0] a);
    exp_q.push_back({ok, e, ae, ov, lvl, g, a});
    name_q.push_back(nm);
  endtask

  task automatic settle(input logic [4:0] wg);
    repeat (3) step(wg, 1'b0);
  endtask

  // Raise reset between clock edges; the snapshot is taken before the next edge.
  task automatic reset_mid(input string nm);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_out(nm, 0, 1, 1, 0, 5'd0, 5'h00, 4'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    string        nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {rd_ok, empty, almost_empty, ovf_err, level, rd_gray, rd_addr};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got ok=%b empty=%b ae=%b ovf=%b level=%0d gray=%h addr=%0d, want ok=%b empty=%b ae=%b ovf=%b level=%0d gray=%h addr=%0d",
                 nm, act_v[17], act_v[16], act_v[15], act_v[14], act_v[13:9], act_v[8:4], act_v[3:0],
                 exp_v[17], exp_v[16], exp_v[15], exp_v[14], exp_v[13:9], exp_v[8:4], exp_v[3:0]);
      end
    end
  end

  // Stimulus
  initial begin
    rst     = 1'b1;
    wr_gray = 5'h00;
    rd_en   = 1'b0;
    @(posedge clk);
    #1;
    expect_out("reset_hold", 0, 1, 1, 0, 5'd0, 5'h00, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill: 01, 03, 02 one per clock
    step(5'h01, 0); expect_out("fill_e1", 0, 1, 1, 0, 5'd0, 5'h00, 4'd0);
    step(5'h03, 0); expect_out("fill_e2", 0, 1, 1, 0, 5'd0, 5'h00, 4'd0);
    step(5'h02, 0); expect_out("fill_e3", 0, 1, 1, 0, 5'd0, 5'h00, 4'd0);
    step(5'h02, 0); expect_out("fill_lvl1", 0, 0, 1, 0, 5'd1, 5'h00, 4'd0);
    step(5'h02, 0); expect_out("fill_lvl2", 0, 0, 0, 0, 5'd2, 5'h00, 4'd0);
    step(5'h02, 0); expect_out("fill_lvl3", 0, 0, 0, 0, 5'd3, 5'h00, 4'd0);

    // Drain: rd_en high for 4 cycles, 3 pops accepted
    step(5'h02, 1); expect_out("drain_req", 1, 0, 0, 0, 5'd3, 5'h00, 4'd0);
    step(5'h02, 1); expect_out("drain_pop1", 1, 0, 0, 0, 5'd2, 5'h01, 4'd1);
    step(5'h02, 1); expect_out("drain_pop2", 1, 0, 1, 0, 5'd1, 5'h03, 4'd2);
    step(5'h02, 1); expect_out("drain_pop3", 0, 1, 1, 0, 5'd0, 5'h02, 4'd3);
    step(5'h02, 0); expect_out("drain_ignored", 0, 1, 1, 0, 5'd0, 5'h02, 4'd3);

    // Writer to 19 one code per clock: full at rd_bin=3
    for (int w = 4; w <= 19; w++) step(to_gray(w), 0);
    settle(5'h1A);
    expect_out("full_at_rd3", 0, 0, 0, 0, 5'd16, 5'h02, 4'd3);

    // 16 pops -> rd_bin=19
    repeat (16) step(5'h1A, 1);
    step(5'h1A, 0);
    expect_out("drain16", 0, 1, 1, 0, 5'd0, 5'h1A, 4'd3);

    // Writer wraps to 34 mod 32 = 2
    for (int w = 20; w <= 34; w++) step(to_gray(w % 32), 0);
    settle(5'h03);
    expect_out("wr_wrapped", 0, 0, 0, 0, 5'd15, 5'h1A, 4'd3);

    // 11 pops -> rd_bin=30, wr_bin=2, level 4
    repeat (11) step(5'h03, 1);
    step(5'h03, 0);
    expect_out("wrap_lvl4", 0, 0, 0, 0, 5'd4, 5'h11, 4'd14);
    step(5'h03, 1); expect_out("wrap_req", 1, 0, 0, 0, 5'd4, 5'h11, 4'd14);
    step(5'h03, 1); expect_out("wrap_rd31", 1, 0, 0, 0, 5'd3, 5'h10, 4'd15);
    step(5'h03, 0); expect_out("wrap_rd0", 0, 0, 0, 0, 5'd2, 5'h00, 4'd0);

    // Full and overflow with rd_bin=0
    for (int w = 3; w <= 16; w++) step(to_gray(w), 0);
    settle(5'h18);
    expect_out("full16", 0, 0, 0, 0, 5'd16, 5'h00, 4'd0);
    step(5'h19, 0);
    settle(5'h19);
    expect_out("ovf_set", 0, 0, 0, 1, 5'd17, 5'h00, 4'd0);
    step(5'h18, 0);
    settle(5'h18);
    expect_out("ovf_sticky", 0, 0, 0, 1, 5'd16, 5'h00, 4'd0);

    reset_mid("reset_clears_ovf");
    wr_gray = 5'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset during traffic at level 5
    for (int w = 1; w <= 5; w++) step(to_gray(w), 0);
    settle(5'h07);
    expect_out("lvl5", 0, 0, 0, 0, 5'd5, 5'h00, 4'd0);
    step(5'h07, 1); expect_out("lvl5_req", 1, 0, 0, 0, 5'd5, 5'h00, 4'd0);
    reset_mid("reset_in_traffic");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(5'h07, 1); expect_out("post_rst_e1", 0, 1, 1, 0, 5'd0, 5'h00, 4'd0);
    step(5'h07, 1); expect_out("post_rst_e2", 0, 1, 1, 0, 5'd0, 5'h00, 4'd0);
    step(5'h07, 1); expect_out("post_rst_e3", 1, 0, 0, 0, 5'd5, 5'h00, 4'd0);
    step(5'h07, 0); expect_out("post_rst_pop", 0, 0, 0, 0, 5'd4, 5'h01, 4'd1);

    // Final report
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
